// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan engine: character codes,
// digit-select patterns, FSM state encoding and the segment glyph values.
package seg_scan_driver_pkg;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   // Character codes: 0-15 hex, 16-35 letters G..Z, then punctuation
   localparam logic [5:0] CH_HEX_0   = 6'd0;
   localparam logic [5:0] CH_HEX_F   = 6'd15;
   localparam logic [5:0] CH_LET_G   = 6'd16;
   localparam logic [5:0] CH_LET_Z   = 6'd35;
   localparam logic [5:0] CH_DASH    = 6'd36;
   localparam logic [5:0] CH_UNDER   = 6'd37;
   localparam logic [5:0] CH_DP      = 6'd62;
   localparam logic [5:0] CH_BLANK   = 6'd63;
   localparam logic [5:0] CH_SPACE   = CH_BLANK;

   // Segment patterns {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_OFF    = 8'h00;

   // Digit select: ch0..ch7 are one-hot, ch8 is all digits off
   localparam logic [7:0] DIG_OFF    = 8'h00;

   function automatic logic [7:0] dig_onehot(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

endpackage

// File: rtl/seg_char_decode.sv
// Combinational character-code to segment-pattern lookup.
// Letters 16-35 map to G..Z using the usual 7-segment approximations.
module seg_char_decode
   import seg_scan_driver_pkg::*;
(
   input  logic [5:0] code,
   output logic [7:0] seg
);

   // Table lookup; anything not listed decodes to all segments off
   always_comb begin
      seg = SEG_OFF;
      case (code)
         6'd0:  seg = 8'h3F;   // 0
         6'd1:  seg = 8'h06;   // 1
         6'd2:  seg = 8'h5B;   // 2
         6'd3:  seg = 8'h4F;   // 3
         6'd4:  seg = 8'h66;   // 4
         6'd5:  seg = 8'h6D;   // 5
         6'd6:  seg = 8'h7D;   // 6
         6'd7:  seg = 8'h07;   // 7
         6'd8:  seg = 8'h7F;   // 8
         6'd9:  seg = 8'h6F;   // 9
         6'd10: seg = 8'h77;   // A
         6'd11: seg = 8'h7C;   // b
         6'd12: seg = 8'h39;   // C
         6'd13: seg = 8'h5E;   // d
         6'd14: seg = 8'h79;   // E
         6'd15: seg = 8'h71;   // F
         6'd16: seg = 8'h3D;   // G
         6'd17: seg = 8'h76;   // H
         6'd18: seg = 8'h30;   // I
         6'd19: seg = 8'h1E;   // J
         6'd20: seg = 8'h75;   // K
         6'd21: seg = 8'h38;   // L
         6'd22: seg = 8'h37;   // M
         6'd23: seg = 8'h54;   // n
         6'd24: seg = 8'h5C;   // o
         6'd25: seg = 8'h73;   // P
         6'd26: seg = 8'h67;   // q
         6'd27: seg = 8'h50;   // r
         6'd28: seg = 8'h6D;   // S
         6'd29: seg = 8'h78;   // t
         6'd30: seg = 8'h3E;   // U
         6'd31: seg = 8'h1C;   // v
         6'd32: seg = 8'h2A;   // W
         6'd33: seg = 8'h49;   // X
         6'd34: seg = 8'h6E;   // y
         6'd35: seg = 8'h5B;   // Z
         6'd36: seg = 8'h40;   // '-'
         6'd37: seg = 8'h08;   // '_'
         6'd62: seg = 8'h80;   // decimal point only
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan engine.
// Each slot is DIV cycles: BLANK_CYC dark cycles, then the digit is shown.
// Optional digit blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 1000,
   parameter int BLINK_FRM = 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [47:0] char_vec,
   input  logic [7:0]  dig_en,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  seg,
   output logic [7:0]  dig_sel,
   output logic [2:0]  scan_idx,
   output logic        frame_tick
);

   localparam int            CW         = $clog2(DIV);
   localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] LAST_SHOW  = CW'(DIV - 1);

   scan_state_t    state;
   logic [CW-1:0]  cnt;
   logic [5:0]     code_q;
   logic [7:0][5:0] chars;
   logic [5:0]     dec_code;
   logic [7:0]     dec_seg;
   logic [7:0]     show_sel;
   logic           blink_hide;
   logic           slot_end;

   assign chars    = char_vec;
   // During BLANK the decoder looks at the live code so the first SHOW cycle
   // already has the right pattern; afterwards it only sees the latched code.
   assign dec_code = (state == ST_BLANK) ? chars[scan_idx] : code_q;
   assign slot_end = (state == ST_SHOW) && (cnt == LAST_SHOW);
   assign show_sel = (dig_en[scan_idx] && !blink_hide) ? dig_onehot(scan_idx) : DIG_OFF;

   seg_char_decode u_dec (
      .code (dec_code),
      .seg  (dec_seg)
   );

   // Scan FSM; outputs are registered alongside the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         scan_idx   <= '0;
         code_q     <= '0;
         seg        <= SEG_OFF;
         dig_sel    <= DIG_OFF;
         frame_tick <= 1'b0;
      end else if (!en) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         scan_idx   <= '0;
         seg        <= SEG_OFF;
         dig_sel    <= DIG_OFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         case (state)
            ST_IDLE: begin
               state   <= ST_BLANK;
               cnt     <= '0;
               seg     <= SEG_OFF;
               dig_sel <= DIG_OFF;
            end
            ST_BLANK: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_BLANK) begin
                  state   <= ST_SHOW;
                  code_q  <= chars[scan_idx];
                  seg     <= dec_seg;
                  dig_sel <= show_sel;
               end else begin
                  seg     <= SEG_OFF;
                  dig_sel <= DIG_OFF;
               end
            end
            ST_SHOW: begin
               if (slot_end) begin
                  state      <= ST_BLANK;
                  cnt        <= '0;
                  scan_idx   <= scan_idx + 1'b1;
                  frame_tick <= (scan_idx == 3'd7);
                  seg        <= SEG_OFF;
                  dig_sel    <= DIG_OFF;
               end else begin
                  cnt     <= cnt + 1'b1;
                  seg     <= dec_seg;
                  dig_sel <= show_sel;
               end
            end
            default: begin
               state   <= ST_IDLE;
               seg     <= SEG_OFF;
               dig_sel <= DIG_OFF;
            end
         endcase
      end
   end

`ifdef SEG_BLINK_EN
   localparam int FW = $clog2(BLINK_FRM + 1);

   logic          blink_ph;
   logic [FW-1:0] frm_cnt;

   assign blink_hide = blink_ph & blink_mask[scan_idx];

   // Blink phase flips after every BLINK_FRM completed frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_ph <= 1'b0;
         frm_cnt  <= '0;
      end else if (!en) begin
         blink_ph <= 1'b0;
         frm_cnt  <= '0;
      end else if (slot_end && (scan_idx == 3'd7)) begin
         if (frm_cnt == FW'(BLINK_FRM - 1)) begin
            frm_cnt  <= '0;
            blink_ph <= ~blink_ph;
         end else begin
            frm_cnt  <= frm_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_blink;

   assign blink_hide   = 1'b0;
   assign unused_blink = ^{blink_mask, BLINK_FRM};
`endif

endmodule
